// File: rtl/uart_af.sv
// uart_af: 8N1 UART on the CPU bus, pins routed through GPIO alternate functions.
// Define UART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO (default: single entry).
module uart_af #(
  parameter logic [15:0] DIV_RESET = 16'd233,
  parameter int unsigned RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [4:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        tx_out,
  output logic        tx_oe,
  input  logic        rx_in
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_e;

  logic        ready_q;
  logic [31:0] data_q, rdata;
  logic [15:0] div_q, divx;
  logic [1:0]  ctrl_q;
  logic        acc, wr, rd;
  logic        a_data, a_stat, a_div, a_ctrl;
  logic        ovr_q, ferr_q;
  logic        tx_off, unused;

  st_e         tx_st_q;
  logic [15:0] tx_cnt_q;
  logic [7:0]  tx_sh_q, hold_q;
  logic [2:0]  tx_bit_q;
  logic        tx_out_q, hold_v_q;

  st_e         rx_st_q;
  logic [15:0] rx_cnt_q;
  logic [7:0]  rx_sh_q, rx_head;
  logic [2:0]  rx_bit_q;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic        rx_done, push, pop, push_ok, ovr_set, ferr_set;
  logic        rx_valid, rx_full;

  assign acc    = select & ~ready_q;
  assign wr     = acc & (|wstrb);
  assign rd     = acc & ~(|wstrb);
  assign a_data = addr == 5'h00;
  assign a_stat = addr == 5'h04;
  assign a_div  = addr == 5'h08;
  assign a_ctrl = addr == 5'h0C;
  assign divx   = (div_q < 16'd7) ? 16'd7 : div_q;
  assign tx_off = wr & a_ctrl & ~data_i[0] & ctrl_q[0];
  assign unused = ^data_i[31:16];

  assign ready  = ready_q;
  assign data_o = data_q;
  assign tx_out = tx_out_q;
  assign tx_oe  = ctrl_q[0];

  assign rx_done  = (rx_st_q == STOP) & (rx_cnt_q == 16'd0) & ctrl_q[1];
  assign push     = rx_done & rx_s2_q;
  assign ferr_set = rx_done & ~rx_s2_q;
  assign pop      = rd & a_data & rx_valid;
  assign push_ok  = push & (~rx_full | pop);
  assign ovr_set  = push & rx_full & ~pop;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      a_data:  rdata = rx_valid ? {23'd0, 1'b1, rx_head} : 32'd0;
      a_stat:  rdata = {27'd0, ferr_q, ovr_q, rx_valid, hold_v_q,
                        tx_st_q != IDLE};
      a_div:   rdata = {16'd0, div_q};
      a_ctrl:  rdata = {30'd0, ctrl_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      data_q  <= '0;
      div_q   <= DIV_RESET;
      ctrl_q  <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ready_q <= select;
      if (rd) data_q <= rdata;
      if (wr && a_div) div_q <= data_i[15:0];
      if (wr && a_ctrl) ctrl_q <= data_i[1:0];
      ovr_q  <= ovr_set | (ovr_q & ~(rd & a_stat));
      ferr_q <= ferr_set | (ferr_q & ~(rd & a_stat));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st_q  <= IDLE;
      tx_cnt_q <= '0;
      tx_sh_q  <= '0;
      tx_bit_q <= '0;
      tx_out_q <= 1'b1;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      if (wr && a_data && !hold_v_q) begin
        hold_q   <= data_i[7:0];
        hold_v_q <= 1'b1;
      end
      if (tx_off) hold_v_q <= 1'b0;
      if (!ctrl_q[0]) begin
        tx_st_q  <= IDLE;
        tx_out_q <= 1'b1;
      end else if (tx_st_q == IDLE) begin
        if (hold_v_q) begin
          tx_st_q  <= START;
          tx_out_q <= 1'b0;
          tx_sh_q  <= hold_q;
          hold_v_q <= 1'b0;
          tx_cnt_q <= divx;
        end
      end else if (tx_cnt_q != 16'd0) begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end else begin
        tx_cnt_q <= divx;
        unique case (tx_st_q)
          START: begin
            tx_st_q  <= DATA;
            tx_out_q <= tx_sh_q[0];
            tx_bit_q <= 3'd0;
          end
          DATA: begin
            if (tx_bit_q == 3'd7) begin
              tx_st_q  <= STOP;
              tx_out_q <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= tx_sh_q >> 1;
              tx_out_q <= tx_sh_q[1];
            end
          end
          STOP: begin
            // back-to-back frames: no idle gap when holding is full
            if (hold_v_q) begin
              tx_st_q  <= START;
              tx_out_q <= 1'b0;
              tx_sh_q  <= hold_q;
              hold_v_q <= 1'b0;
            end else begin
              tx_st_q <= IDLE;
            end
          end
          default: tx_st_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_st_q  <= IDLE;
      rx_cnt_q <= '0;
      rx_sh_q  <= '0;
      rx_bit_q <= '0;
    end else begin
      rx_s1_q <= rx_in;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      if (!ctrl_q[1]) begin
        rx_st_q <= IDLE;
      end else if (rx_st_q == IDLE) begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_st_q  <= START;
          rx_cnt_q <= (divx - 16'd1) >> 1;
        end
      end else if (rx_cnt_q != 16'd0) begin
        rx_cnt_q <= rx_cnt_q - 16'd1;
      end else begin
        rx_cnt_q <= divx;
        unique case (rx_st_q)
          START: begin
            rx_st_q  <= rx_s2_q ? IDLE : DATA;
            rx_bit_q <= 3'd0;
          end
          DATA: begin
            rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_st_q <= STOP;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end
          default: rx_st_q <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW = $clog2(RX_DEPTH);
  logic [7:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;

  assign rx_valid = cnt_q != '0;
  assign rx_full  = cnt_q == (AW+1)'(RX_DEPTH);
  assign rx_head  = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      if (push_ok && !pop) cnt_q <= cnt_q + (AW+1)'(1);
      else if (!push_ok && pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end
`else
  localparam int unsigned rx_depth_unused = RX_DEPTH;
  logic [7:0] rxb_q;
  logic       rxv_q;

  assign rx_valid = rxv_q;
  assign rx_full  = rxv_q;
  assign rx_head  = rxb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxb_q <= '0;
      rxv_q <= 1'b0;
    end else if (push_ok) begin
      rxb_q <= rx_sh_q;
      rxv_q <= 1'b1;
    end else if (pop) begin
      rxv_q <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_uart_af.sv
// Scoreboard bench for uart_af: bus reads and TX frames are checked
// by monitors against queues filled at stimulus time.
module tb_uart_af;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        select = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [4:0]  addr = '0;
  logic [31:0] data_i = '0;
  logic        ready;
  logic [31:0] data_o;
  logic        tx_out, tx_oe;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_in;
  logic        tx_mon_en = 1'b0;

  assign rx_in = loop_en ? tx_out : rx_drv;

  uart_af dut (
    .clk(clk), .reset_n(reset_n), .select(select), .wstrb(wstrb),
    .addr(addr), .data_i(data_i), .ready(ready), .data_o(data_o),
    .tx_out(tx_out), .tx_oe(tx_oe), .rx_in(rx_in)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_rd;
    logic [31:0] val;
  } acc_t;
  typedef struct {
    logic [7:0] b;
    logic       b2b;
  } txf_t;

  acc_t  rdq[$];
  string nmq[$];
  txf_t  txq[$];

`ifdef UART_RX_FIFO_EN
  localparam int NOVR = 4 + 1;
`else
  localparam int NOVR = 2;
`endif
  logic [7:0] ovr_bytes [5] = '{8'h81, 8'h7E, 8'hC3, 8'h24, 8'h99};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus(logic [4:0] a, logic [3:0] ws, logic [31:0] d,
                     int hold, logic is_rd, logic [31:0] ev, string nm);
    acc_t e;
    @(posedge clk);
    #1;
    e.is_rd = is_rd;
    e.val = ev;
    rdq.push_back(e);
    nmq.push_back(nm);
    select = 1'b1;
    addr = a;
    wstrb = ws;
    data_i = d;
    repeat (hold) @(posedge clk);
    #1;
    select = 1'b0;
    wstrb = '0;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    bus(a, 4'hF, d, 1, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(logic [4:0] a, logic [31:0] ev, string nm, int hold = 1);
    bus(a, 4'h0, 32'd0, hold, 1'b1, ev, nm);
  endtask

  task automatic inject(logic [7:0] b, logic stopb);
    @(posedge clk);
    #1 rx_drv = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_drv = b[i];
      repeat (10) @(posedge clk);
    end
    #1 rx_drv = stopb;
    repeat (10) @(posedge clk);
    #1 rx_drv = 1'b1;
  endtask

  // bus monitor: one scoreboard pop per acknowledged access
  logic        mon_rp = 1'b0;
  logic [31:0] mon_last = '0;
  initial begin : bus_mon
    acc_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_rp = 1'b0;
        mon_last = '0;
      end else begin
        if (ready && !mon_rp) begin
          if (rdq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL bus_unexpected: got ack expected none");
          end else begin
            e = rdq.pop_front();
            nm = nmq.pop_front();
            if (e.is_rd) begin
              chk(nm, data_o, e.val);
              mon_last = e.val;
            end
          end
        end else if (ready && mon_rp) begin
          chk("data_o_stable", data_o, mon_last);
        end
        mon_rp = ready;
      end
    end
  end

  // TX line monitor: exact 10-clock bit cells, frames compared in order
  logic [7:0] txb;
  logic       txok;
  int         tstart;
  int         tend = -100;
  initial begin : tx_mon
    txf_t e;
    forever begin
      @(negedge clk);
      if (tx_mon_en && tx_oe && tx_out == 1'b0) begin
        tstart = cyc;
        txok = 1'b1;
        txb = '0;
        for (int i = 1; i < 10; i++) begin
          @(negedge clk);
          if (tx_out !== 1'b0) txok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) txb[b] = tx_out;
            else if (tx_out !== txb[b]) txok = 1'b0;
          end
        end
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (tx_out !== 1'b1) txok = 1'b0;
        end
        if (txq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got frame 0x%0h expected none", txb);
        end else begin
          e = txq.pop_front();
          chk("tx_byte", {24'd0, txb}, {24'd0, e.b});
          chk("tx_timing", {31'd0, txok}, 32'd1);
          if (e.b2b) chk("tx_b2b_start", tstart, tend + 1);
        end
        tend = cyc;
      end
    end
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
    chk("rst_tx_oe", {31'd0, tx_oe}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    reset_n = 1'b1;
    rd(5'h08, 32'd233, "div_rst");
    rd(5'h04, 32'd0, "status_rst");
    rd(5'h0C, 32'd0, "ctrl_rst");
    wr(5'h08, 32'd3);
    rd(5'h08, 32'd3, "div_small_stored");

    // reset pulse during data bit 3
    wr(5'h08, 32'd9);
    wr(5'h0C, 32'd1);
    wr(5'h00, 32'h5A);
    repeat (44) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("midrst_tx_out", {31'd0, tx_out}, 32'd1);
    chk("midrst_tx_oe", {31'd0, tx_oe}, 32'd0);
    rd(5'h04, 32'd0, "midrst_status");
    rd(5'h08, 32'd233, "midrst_div");

    // single frame 0xA5
    wr(5'h08, 32'd9);
    wr(5'h0C, 32'd1);
    tx_mon_en = 1'b1;
    txq.push_back('{8'hA5, 1'b0});
    wr(5'h00, 32'hA5);
    rd(5'h04, 32'h1, "status_busy");
    repeat (110) @(posedge clk);
    rd(5'h04, 32'h0, "status_idle");

    // back-to-back frames, third write dropped
    txq.push_back('{8'h11, 1'b0});
    txq.push_back('{8'h22, 1'b1});
    wr(5'h00, 32'h11);
    wr(5'h00, 32'h22);
    wr(5'h00, 32'h33);
    rd(5'h04, 32'h3, "status_full");
    repeat (240) @(posedge clk);
    rd(5'h04, 32'h0, "status_after_b2b");
    chk("tx_queue_drained", txq.size(), 32'd0);

    // loopback receive of 0x3C
    wr(5'h0C, 32'd3);
    loop_en = 1'b1;
    txq.push_back('{8'h3C, 1'b0});
    wr(5'h00, 32'h3C);
    repeat (120) @(posedge clk);
    rd(5'h04, 32'h4, "status_rx_valid");
    rd(5'h00, 32'h13C, "rx_data_held", 3);
    rd(5'h04, 32'h0, "status_rx_empty");
    rd(5'h00, 32'h0, "rx_data_empty");
    loop_en = 1'b0;
    wr(5'h0C, 32'd2);

    // framing error
    inject(8'h55, 1'b0);
    repeat (5) @(posedge clk);
    rd(5'h04, 32'h10, "status_frame_err");
    rd(5'h04, 32'h0, "status_ferr_clr");

    // overrun: buffer fills, last byte lost
    for (int i = 0; i < NOVR; i++) inject(ovr_bytes[i], 1'b1);
    repeat (5) @(posedge clk);
    rd(5'h04, 32'hC, "status_overrun");
    for (int i = 0; i < NOVR - 1; i++)
      rd(5'h00, {23'd0, 1'b1, ovr_bytes[i]}, "rx_order");
    rd(5'h00, 32'h0, "rx_last_lost");
    rd(5'h04, 32'h0, "status_ovr_clr");

    // one-cycle glitch is not a start bit
    @(posedge clk);
    #1 rx_drv = 1'b0;
    @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (30) @(posedge clk);
    rd(5'h04, 32'h0, "status_glitch");
    rd(5'h00, 32'h0, "rx_glitch_nobyte");

    repeat (5) @(posedge clk);
    chk("bus_queue_drained", rdq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
